regfile_sequencer: RTL
======================

Name: regfile_sequencer

Overview:
Control stage directly upstream of the register card. Accepts one decoded-from-raw RV32I instruction word, drives the card's active-low read/write strobes and the rs1a/rs2a/rda addresses, captures rs1/rs2 operands and presents them downstream. Accepts the write-back value and produces a clean, timed n_rd_wr pulse, with address/data setup and hold around it. Handles one instruction at a time, with no pipelining.

Parameters:
READ_SETTLE, 2, cycles read enables are held low before operands are captured (min 1)
WR_PULSE, 2, cycles n_rd_wr is held low (min 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
inst_valid  in  1  instruction offered
inst_ready  out  1  sequencer idle, will accept
inst  in  32  raw RV32I instruction
n_rs1_rd  out  1  register card rs1 output enable, active low
n_rs2_rd  out  1  register card rs2 output enable, active low
n_rd_wr  out  1  register card write strobe, active low
rs1a  out  5  rs1 address
rs2a  out  5  rs2 address
rda  out  5  rd address
rs1_in  in  32  rs1 bus from card
rs2_in  in  32  rs2 bus from card
rd_out  out  32  write data to card
op_valid  out  1  operands available downstream
op_ready  in  1  downstream takes operands
op_inst  out  32  latched instruction
op_rs1  out  32  captured rs1 (0 if unused)
op_rs2  out  32  captured rs2 (0 if unused)
wb_valid  in  1  write-back value offered
wb_ready  out  1  sequencer accepts write-back
wb_data  in  32  write-back value
illegal  out  1  one-cycle pulse, unrecognised opcode

Behaviour:
- Reset (sync, active-high) values: state IDLE; inst_ready=1; n_rs1_rd=n_rs2_rd=n_rd_wr=1; rs1a=rs2a=rda=0; rd_out=0; op_valid=0; wb_ready=0; op_*=0; illegal=0. Reset in any state, including mid-WPULSE, forces n_rd_wr=1 at the next edge. The pending write is dropped.
- Decode on opcode inst[6:0]; fields are rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]. The class sets use_rs1, use_rs2 and use_rd:
  - R 0110011: rs1, rs2, rd
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: rs1, rd
  - STORE 0100011, BRANCH 1100011: rs1, rs2
  - LUI 0110111, AUIPC 0010111, JAL 1101111: rd
  - all other opcodes: illegal
- Accept on inst_valid&&inst_ready, which is only asserted in IDLE. The instruction, fields and use flags are latched. Addresses of unused fields are driven 0.
- Illegal: after acceptance, illegal=1 for exactly 1 cycle, then IDLE. No strobes and no op_valid.
- States:
  - IDLE -> ADDR. Addresses are registered; enables stay high for 1 setup cycle.
  - ADDR -> READ. Only if use_rs1|use_rs2; otherwise go straight to OP.
  - READ: n_rs1_rd low iff use_rs1, n_rs2_rd low iff use_rs2, for READ_SETTLE cycles. rs1_in/rs2_in are captured on the last cycle; unused operands are captured as 0. Enables go high on leaving.
  - OP: op_valid=1 until op_ready. Outputs are stable while op_valid is high. Handshake -> WB.
  - WB: wb_ready=1. On wb_valid, wb_data is latched into rd_out. If use_rd && rda!=0, go to WSETUP; otherwise go to IDLE (STORE/BRANCH still complete one wb handshake, with data discarded).
  - WSETUP: 1 cycle, n_rd_wr=1, rda and rd_out stable.
  - WPULSE: n_rd_wr=0 for WR_PULSE cycles.
  - WHOLD: 1 cycle, n_rd_wr=1, rda and rd_out held -> IDLE.
- x0 writes are never strobed. Reads of x0 are strobed normally; the card supplies zero.
- Any wb_valid seen outside WB is ignored. Any inst_valid seen outside IDLE is ignored.
- n_rd_wr and the read enables are never low simultaneously.
- All outputs are registered, with no combinational path from inputs to outputs.
- Minimum latency, accept to inst_ready, for R-type with zero-wait handshakes: 1 + 1 + READ_SETTLE + 1 + 1 + 1 + WR_PULSE + 1 cycles = 10 with defaults.

Decomposition:
- Package regfile_seq_pkg holds the opcode constants, the state enum, and an inst_class typedef (R, RS1_RD, RS1_RS2, RD_ONLY, ILLEGAL).
- Sub-module rv_reg_decode: purely combinational. It maps inst to {rs1a, rs2a, rda, use_rs1, use_rs2, use_rd, illegal}.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), card rs1=0x11111111, rs2=0x22222222, wb_data=0xF0E0D0C0 -> rs1a=1, rs2a=2; both enables low 2 cycles; op_rs1/op_rs2 as given. rda=3, rd_out=0xF0E0D0C0, n_rd_wr low exactly 2 cycles, then inst_ready after 10 cycles total.
- ADDI x0,x0,0 (0x00000013) -> rs1 read strobed, op_rs2=0, wb handshake completes, n_rd_wr never asserted.
- SW x2,0(x1) (0x0020A023) -> both reads strobed, wb accepted and discarded, no write pulse.
- LUI x5,0x12345 (0x123452B7) -> no read strobes, op_valid 2 cycles after accept, write to rda=5.
- Opcode 0x7F -> illegal pulses 1 cycle, all strobes stay high, inst_ready back next cycle.
- Assert rst during WPULSE, and hold op_ready=0 for 5 cycles in a separate run -> n_rd_wr=1 on the next edge and the state returns to IDLE. With op_ready held low, op_valid and op_* stay stable and n_rd_wr stays high throughout.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// Opcode constants, sequencer FSM states and instruction register-usage classes
// shared by the register-card sequencer and its decoder.
package regfile_seq_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_OP,
        S_WB,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_ILL
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_RS1_RD,
        CLS_RS1_RS2,
        CLS_RD_ONLY,
        CLS_ILLEGAL
    } inst_class_t;

    function automatic inst_class_t classify(input logic [6:0] opcode);
        inst_class_t cls;
        case (opcode)
            OPC_OP:                         cls = CLS_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: cls = CLS_RS1_RD;
            OPC_STORE, OPC_BRANCH:          cls = CLS_RS1_RS2;
            OPC_LUI, OPC_AUIPC, OPC_JAL:    cls = CLS_RD_ONLY;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv_reg_decode.sv
// Combinational RV32I register-field decoder: addresses of unused fields are
// forced to zero so the card never sees a stray address.
module rv_reg_decode
    import regfile_seq_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1a,
    output logic [4:0]  rs2a,
    output logic [4:0]  rda,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        use_rd,
    output logic        illegal
);

    inst_class_t cls;
    logic        unused_bits;

    // funct3/funct7 do not affect register usage
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    always_comb begin
        cls     = classify(inst[6:0]);
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        case (cls)
            CLS_R:       begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            CLS_RS1_RD:  begin use_rs1 = 1'b1; use_rd = 1'b1; end
            CLS_RS1_RS2: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            CLS_RD_ONLY: use_rd = 1'b1;
            default:     illegal = 1'b1;
        endcase
        rs1a = use_rs1 ? inst[19:15] : 5'd0;
        rs2a = use_rs2 ? inst[24:20] : 5'd0;
        rda  = use_rd  ? inst[11:7]  : 5'd0;
    end

endmodule

// File: rtl/regfile_sequencer.sv
// One-instruction-at-a-time sequencer in front of the register card: timed
// active-low read enables, operand capture, and a setup/pulse/hold write strobe.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int READ_SETTLE = 2,
    parameter int WR_PULSE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    output logic        n_rs1_rd,
    output logic        n_rs2_rd,
    output logic        n_rd_wr,
    output logic [4:0]  rs1a,
    output logic [4:0]  rs2a,
    output logic [4:0]  rda,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    output logic [31:0] rd_out,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_inst,
    output logic [31:0] op_rs1,
    output logic [31:0] op_rs2,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_data,
    output logic        illegal
);

    localparam int               CNT_W     = 8;
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_SETTLE - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_PULSE - 1);

    seq_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             use_rs1_q, use_rs2_q, use_rd_q;
    logic [4:0]       dec_rs1a, dec_rs2a, dec_rda;
    logic             dec_use_rs1, dec_use_rs2, dec_use_rd, dec_illegal;
    logic             accept, read_done;

    rv_reg_decode u_decode (
        .inst    (inst),
        .rs1a    (dec_rs1a),
        .rs2a    (dec_rs2a),
        .rda     (dec_rda),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2),
        .use_rd  (dec_use_rd),
        .illegal (dec_illegal)
    );

    assign accept    = inst_valid && inst_ready;
    assign read_done = (state == S_READ) && (cnt == READ_LAST);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE:   if (accept) state_d = dec_illegal ? S_ILL : S_ADDR;
            S_ADDR: begin
                if (use_rs1_q || use_rs2_q) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else begin
                    state_d = S_OP;
                end
            end
            S_READ:   if (read_done) state_d = S_OP; else cnt_d = cnt + 1'b1;
            S_OP:     if (op_ready) state_d = S_WB;
            // x0 and store/branch write-backs are consumed without a strobe
            S_WB:     if (wb_valid) state_d = (use_rd_q && rda != 5'd0) ? S_WSETUP : S_IDLE;
            S_WSETUP: begin state_d = S_WPULSE; cnt_d = '0; end
            S_WPULSE: if (cnt == WR_LAST) state_d = S_WHOLD; else cnt_d = cnt + 1'b1;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes and handshakes are decoded from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            use_rs1_q  <= 1'b0;
            use_rs2_q  <= 1'b0;
            use_rd_q   <= 1'b0;
            inst_ready <= 1'b1;
            n_rs1_rd   <= 1'b1;
            n_rs2_rd   <= 1'b1;
            n_rd_wr    <= 1'b1;
            rs1a       <= '0;
            rs2a       <= '0;
            rda        <= '0;
            rd_out     <= '0;
            op_valid   <= 1'b0;
            wb_ready   <= 1'b0;
            op_inst    <= '0;
            op_rs1     <= '0;
            op_rs2     <= '0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            inst_ready <= (state_d == S_IDLE);
            n_rs1_rd   <= !((state_d == S_READ) && use_rs1_q);
            n_rs2_rd   <= !((state_d == S_READ) && use_rs2_q);
            n_rd_wr    <= (state_d != S_WPULSE);
            op_valid   <= (state_d == S_OP);
            wb_ready   <= (state_d == S_WB);
            illegal    <= (state_d == S_ILL);
            if (accept) begin
                op_inst   <= inst;
                rs1a      <= dec_rs1a;
                rs2a      <= dec_rs2a;
                rda       <= dec_rda;
                use_rs1_q <= dec_use_rs1;
                use_rs2_q <= dec_use_rs2;
                use_rd_q  <= dec_use_rd;
                op_rs1    <= '0;
                op_rs2    <= '0;
            end
            if (read_done) begin
                op_rs1 <= use_rs1_q ? rs1_in : '0;
                op_rs2 <= use_rs2_q ? rs2_in : '0;
            end
            if (state == S_WB && wb_valid) rd_out <= wb_data;
        end
    end

endmodule
